// File: rtl/gshare_predictor_ctrl.sv
// Gshare PHT controller: sweeps the external 2-bit counter file to weakly-not-taken,
// then serves one lookup and one update per cycle with same-cycle collision bypass and GHR recovery.
module gshare_predictor_ctrl #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned PC_LSB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [1:0]       pred_ctr,
  output logic [IDX_W-1:0] pred_idx,
  output logic [IDX_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [1:0]       upd_ctr,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  input  logic [IDX_W-1:0] upd_ghr,
  output logic             upd_ready,
  output logic             rf_we,
  output logic [IDX_W-1:0] rf_wr_addr,
  output logic [1:0]       rf_data_in,
  output logic [IDX_W-1:0] rf_rd_addr,
  input  logic [1:0]       rf_data_out,
  output logic             init_done
);

  localparam int unsigned CTR_W = 2;
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = 2'b01;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   init_cnt;
  logic [IDX_W-1:0]   ghr;
  logic               pred_shift;
  logic               byp_hit;
  logic [CTR_W-1:0]   byp_ctr;

  logic               lookup_fire;
  logic               upd_fire;
  logic               recover;
  logic [IDX_W-1:0]   lookup_idx;
  logic [CTR_W-1:0]   upd_ctr_nxt;
  logic               unused_bits;

  // Saturating 2-bit counter step.
  function automatic logic [CTR_W-1:0] sat(input logic [CTR_W-1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    else   return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  assign lookup_fire = lookup_valid & lookup_ready;
  assign upd_fire    = upd_valid & upd_ready;
  assign recover     = upd_fire & upd_mispredict;
  assign lookup_idx  = lookup_pc[PC_LSB +: IDX_W] ^ ghr;
  assign upd_ctr_nxt = sat(upd_ctr, upd_taken);
  assign unused_bits = ^{lookup_pc, upd_ghr[IDX_W-1]};

  // Prediction takes the bypassed write data on a same-cycle collision, else the file output.
  always_comb begin
    pred_ctr = '0;
    if (pred_valid) pred_ctr = byp_hit ? byp_ctr : rf_data_out;
    pred_taken = pred_ctr[1];
  end

  // Register-file port drive; write port is owned by the sweep in INIT and by updates in RUN.
  always_comb begin
    rf_we      = 1'b0;
    rf_wr_addr = '0;
    rf_data_in = '0;
    rf_rd_addr = '0;
    if (state == ST_INIT) begin
      if (rst_n) begin
        rf_we      = 1'b1;
        rf_wr_addr = init_cnt;
        rf_data_in = CTR_WEAK_NT;
      end
    end else begin
      rf_rd_addr = lookup_idx;
      if (upd_fire) begin
        rf_we      = 1'b1;
        rf_wr_addr = upd_idx;
        rf_data_in = upd_ctr_nxt;
      end
    end
  end

  // Sequencer, lookup pipeline stage and global history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      ghr          <= '0;
      lookup_ready <= 1'b0;
      upd_ready    <= 1'b0;
      init_done    <= 1'b0;
      pred_valid   <= 1'b0;
      pred_idx     <= '0;
      pred_ghr     <= '0;
      pred_shift   <= 1'b0;
      byp_hit      <= 1'b0;
      byp_ctr      <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + IDX_W'(1);
          if (init_cnt == IDX_W'(DEPTH - 1)) begin
            state        <= ST_RUN;
            lookup_ready <= 1'b1;
            upd_ready    <= 1'b1;
            init_done    <= 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase

      pred_valid <= lookup_fire;
      pred_shift <= lookup_fire & ~recover;
      byp_hit    <= lookup_fire & upd_fire & (upd_idx == lookup_idx);
      byp_ctr    <= upd_ctr_nxt;
      if (lookup_fire) begin
        pred_idx <= lookup_idx;
        pred_ghr <= ghr;
      end

      // A lookup accepted alongside a recovery never shifts its prediction in.
      if (recover)
        ghr <= {upd_ghr[IDX_W-2:0], upd_taken};
      else if (pred_valid && pred_shift)
        ghr <= {ghr[IDX_W-2:0], pred_taken};
    end
  end

endmodule
